// File: rtl/axi4_rd_arbiter.sv
// ============================================================================
// axi4_rd_arbiter : two-master (IFU/LSU) arbiter for one shared AXI4 read
// channel; optional wait-cycle counters under `ARB_PERF_CNT_EN`. Rev 1.0
// ============================================================================
`default_nettype none

module axi4_rd_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int PRIO_M1 = 0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                m0_arvalid,
    output logic                m0_arready,
    input  logic [ADDR_W+10:0]  m0_ar,
    output logic                m0_rvalid,
    input  logic                m0_rready,
    output logic [DATA_W+2:0]   m0_r,
    input  logic                m1_arvalid,
    output logic                m1_arready,
    input  logic [ADDR_W+10:0]  m1_ar,
    output logic                m1_rvalid,
    input  logic                m1_rready,
    output logic [DATA_W+2:0]   m1_r,
    input  logic                lsu_wr_busy,
    output logic                s_arvalid,
    input  logic                s_arready,
    output logic [ADDR_W+10:0]  s_ar,
    input  logic                s_rvalid,
    output logic                s_rready,
    input  logic [DATA_W+2:0]   s_r,
    output logic [1:0]          grant
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]         m0_wait_cycles,
    output logic [31:0]         m1_wait_cycles
`endif
);

    localparam logic FIXED_M1 = (PRIO_M1 != 0);

    // Encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GNT_M0 = 2'b01,
        GNT_M1 = 2'b10
    } state_t;

    state_t state_q, state_d;
    logic   ar_done_q, ar_done_d;
    logic   last_m1_q, last_m1_d;

    logic               m0_elig, m1_elig;
    logic               own_m0, own_m1;
    logic               own_arvalid, own_rready;
    logic [ADDR_W+10:0] own_ar;
    logic               arready_w, rvalid_w;

    assign m0_elig     = m0_arvalid & ~lsu_wr_busy;
    assign m1_elig     = m1_arvalid;
    assign own_m0      = (state_q == GNT_M0);
    assign own_m1      = (state_q == GNT_M1);
    assign own_arvalid = own_m1 ? m1_arvalid : m0_arvalid;
    assign own_ar      = own_m1 ? m1_ar      : m0_ar;
    assign own_rready  = own_m1 ? m1_rready  : m0_rready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ar_done_q <= 1'b0;
            last_m1_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            ar_done_q <= ar_done_d;
            last_m1_q <= last_m1_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ar_done_d = ar_done_q;
        last_m1_d = last_m1_q;
        s_arvalid = 1'b0;
        s_ar      = '0;
        s_rready  = 1'b0;
        arready_w = 1'b0;
        rvalid_w  = 1'b0;
        case (state_q)
            IDLE: begin
                // On a tie, round-robin hands the grant to whoever did not have it last.
                if (m1_elig && (!m0_elig || FIXED_M1 || !last_m1_q)) begin
                    state_d   = GNT_M1;
                    last_m1_d = 1'b1;
                end else if (m0_elig) begin
                    state_d   = GNT_M0;
                    last_m1_d = 1'b0;
                end
            end
            GNT_M0, GNT_M1: begin
                if (!ar_done_q) begin
                    s_arvalid = own_arvalid;
                    s_ar      = own_ar;
                    arready_w = s_arready;
                    if (own_arvalid && s_arready) begin
                        ar_done_d = 1'b1;
                    end
                end else begin
                    rvalid_w = s_rvalid;
                    s_rready = own_rready;
                    if (s_rvalid && own_rready && s_r[0]) begin
                        state_d   = IDLE;
                        ar_done_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                ar_done_d = 1'b0;
            end
        endcase
    end

    assign grant      = state_q;
    assign m0_arready = own_m0 & arready_w;
    assign m1_arready = own_m1 & arready_w;
    assign m0_rvalid  = own_m0 & rvalid_w;
    assign m1_rvalid  = own_m1 & rvalid_w;
    assign m0_r       = own_m0 ? s_r : '0;
    assign m1_r       = own_m1 ? s_r : '0;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] m0_wait_q, m1_wait_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m0_wait_q <= '0;
            m1_wait_q <= '0;
        end else begin
            if (m0_arvalid && !own_m0) m0_wait_q <= m0_wait_q + 32'd1;
            if (m1_arvalid && !own_m1) m1_wait_q <= m1_wait_q + 32'd1;
        end
    end

    assign m0_wait_cycles = m0_wait_q;
    assign m1_wait_cycles = m1_wait_q;
`endif

endmodule

`default_nettype wire
